// File: rtl/block_fir_div_pkg.sv
// Shared definitions for the block FIR sequential signed divider.
//
// Contents:
//   div_state_e      - divider control states
//   DIV_W            - nominal operand width
//   DIV_CNT_W        - width of the iteration counter (holds 0..DIV_W)
//   DIV_BY_ZERO_QUO  - quotient returned when the divisor is zero
package block_fir_div_pkg;

    localparam int unsigned DIV_W     = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_W + 1);

    localparam logic [DIV_W-1:0] DIV_BY_ZERO_QUO = '1;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } div_state_e;

endpackage

// File: rtl/block_fir_udiv_step.sv
// One combinational radix-2 restoring division iteration on unsigned magnitudes.
//
// Ports:
//   rem_i      - partial remainder before this step
//   dvd_bit_i  - next dividend bit shifted into the remainder
//   divisor_i  - divisor magnitude
//   rem_o      - partial remainder after this step
//   q_bit_o    - quotient bit produced by this step
module block_fir_udiv_step #(
    parameter int unsigned Width = 33
) (
    input  logic [Width-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [Width-1:0] divisor_i,
    output logic [Width-1:0] rem_o,
    output logic             q_bit_o
);

    logic [Width:0] shifted;
    logic [Width:0] trial;

    always_comb begin
        shifted = {rem_i, dvd_bit_i};
        trial   = shifted - {1'b0, divisor_i};
        q_bit_o = (shifted >= {1'b0, divisor_i});
        // A kept remainder is always below the divisor, so the top bit is dropped safely.
        rem_o   = q_bit_o ? Width'(trial) : Width'(shifted);
    end

endmodule

// File: rtl/block_fir_sdiv_32s_32s_32_seq.sv
// Sequential signed divider: quotient truncated toward zero, remainder takes the
// dividend's sign. One restoring iteration per clock, one division in flight.
//
// Ports:
//   ap_clk, ap_rst_n    - clock and asynchronous active-low reset
//   in_valid/in_ready   - operand handshake (in_ready is registered)
//   din0, din1          - signed dividend and divisor
//   out_valid/out_ready - result handshake; results held stable until accepted
//   dout_quo, dout_rem  - signed quotient and remainder
//
// Build option BLOCK_FIR_SDIV_REM_EN: when defined the remainder output register
// and its sign fixup are built; otherwise dout_rem is tied to zero.
//
// Divide by zero yields quotient -1 and remainder equal to the dividend; MIN / -1
// wraps to MIN with remainder 0. Latency is W+1 edges from accept to out_valid.
module block_fir_sdiv_32s_32s_32_seq
    import block_fir_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIV_W,
    parameter int din1_WIDTH = DIV_W,
    parameter int dout_WIDTH = DIV_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout_quo,
    output logic [dout_WIDTH-1:0] dout_rem
);

    localparam int unsigned W    = din0_WIDTH;
    localparam int unsigned CntW = $clog2(W + 1);

    // Two's-complement magnitude; MIN maps to 2^(W-1), exact as an unsigned value.
    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? (~x + W'(1)) : x;
    endfunction

    div_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic [W:0]      rem_q;       // partial remainder
    logic [W:0]      dsr_q;       // divisor magnitude
    logic [W-1:0]    dvd_q;       // dividend bits shift out, quotient bits shift in
    logic            neg_quo_q;
    logic            zero_div_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [dout_WIDTH-1:0] quo_q;

    logic            accept;
    logic [W:0]      rem_nxt;
    logic            q_bit;
    logic [W-1:0]    quo_fix;

    assign accept = (state_q == StIdle) && in_valid && in_ready_q;

    block_fir_udiv_step #(
        .Width (W + 1)
    ) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[W-1]),
        .divisor_i (dsr_q),
        .rem_o     (rem_nxt),
        .q_bit_o   (q_bit)
    );

    always_comb begin
        quo_fix = neg_quo_q ? (~dvd_q + W'(1)) : dvd_q;
        if (zero_div_q) begin
            quo_fix = W'(DIV_BY_ZERO_QUO);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            dvd_q       <= '0;
            neg_quo_q   <= 1'b0;
            zero_div_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            quo_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Raises in_ready on the first edge after reset release.
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        rem_q      <= '0;
                        dvd_q      <= mag(din0);
                        dsr_q      <= {1'b0, mag(din1)};
                        neg_quo_q  <= din0[W-1] ^ din1[din1_WIDTH-1];
                        zero_div_q <= (din1 == '0);
                        cnt_q      <= CntW'(W);
                        in_ready_q <= 1'b0;
                        state_q    <= StCalc;
                    end
                end
                StCalc: begin
                    rem_q <= rem_nxt;
                    dvd_q <= {dvd_q[W-2:0], q_bit};
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    quo_q       <= quo_fix;
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dout_quo  = quo_q;

`ifdef BLOCK_FIR_SDIV_REM_EN
    logic                  neg_rem_q;
    logic [dout_WIDTH-1:0] rem_out_q;
    logic [W-1:0]          rem_mag;
    logic [W-1:0]          rem_fix;

    // With a zero divisor every trial succeeds, so the remainder accumulates the
    // dividend magnitude and the sign fixup restores din0 exactly.
    assign rem_mag = W'(rem_q);
    assign rem_fix = neg_rem_q ? (~rem_mag + W'(1)) : rem_mag;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            neg_rem_q <= 1'b0;
            rem_out_q <= '0;
        end else begin
            if (accept) begin
                neg_rem_q <= din0[W-1];
            end
            if (state_q == StFix) begin
                rem_out_q <= rem_fix;
            end
        end
    end

    assign dout_rem = rem_out_q;
`else
    assign dout_rem = '0;
`endif

endmodule

// File: tb/tb_block_fir_sdiv_32s_32s_32_seq.sv
// Self-checking bench for block_fir_sdiv_32s_32s_32_seq: directed literal cases,
// backpressure, randomized back-to-back traffic against an arithmetic model, and
// reset during a division.
module tb_block_fir_sdiv_32s_32s_32_seq;

    localparam int W = 32;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] din0 = '0;
    logic [31:0] din1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] dout_quo;
    logic [31:0] dout_rem;

    int total = 0;
    int bad = 0;

    res_t exp_q[$];
    int   edge_cnt = 0;
    int   accept_edge = 0;
    int   prev_accept = 0;
    bit   have_prev = 0;
    bit   b2b_mode = 0;
    bit   busy = 0;
    bit   prev_ov = 0;
    bit   prev_stall = 0;

    block_fir_sdiv_32s_32s_32_seq dut (
        .ap_clk    (clk),
        .ap_rst_n  (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout_quo  (dout_quo),
        .dout_rem  (dout_rem)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at t=%0t", name, $time);
    endtask

    // Reference: truncating signed division on wide integers, plus the zero-divisor rule.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t   res;
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            res.q = 32'hFFFF_FFFF;
            res.r = a;
        end else begin
            res.q = 32'(sa / sb);
            res.r = 32'(sa % sb);
        end
`ifndef BLOCK_FIR_SDIV_REM_EN
        res.r = 32'd0;
`endif
        return res;
    endfunction

    // Compare process: checks the DUT every cycle against the model queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            busy       = 0;
            prev_ov    = 0;
            prev_stall = 0;
            have_prev  = 0;
        end else begin
            if (!b2b_mode) have_prev = 0;
            if (prev_stall) check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
            if (out_valid && !prev_ov) begin
                check("latency", 32'(edge_cnt - accept_edge), 32'(W + 1));
            end
            if (busy) check("ready_while_busy", {31'd0, in_ready}, 32'd0);
            else      check("valid_while_idle", {31'd0, out_valid}, 32'd0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    check("quo", dout_quo, exp_q[0].q);
                    check("rem", dout_rem, exp_q[0].r);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                busy = 0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(din0, din1));
                accept_edge = edge_cnt + 1;
                if (b2b_mode && have_prev) begin
                    check("issue_interval", 32'(accept_edge - prev_accept), 32'(W + 3));
                end
                prev_accept = accept_edge;
                have_prev   = 1;
                busy        = 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_ov    = out_valid;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        din0     = a;
        din1     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        fail_now("accept_timeout");
    endtask

    // Returns at the negedge where out_valid is first seen.
    task automatic wait_result(input string name, input logic [31:0] eq, input logic [31:0] er);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                check({name, "_quo"}, dout_quo, eq);
`ifdef BLOCK_FIR_SDIV_REM_EN
                check({name, "_rem"}, dout_rem, er);
`else
                check({name, "_rem_tied"}, dout_rem, 32'd0);
                if (er == 32'hDEAD_BEEF) $display("unreachable");
`endif
                return;
            end
        end
        fail_now({name, "_result_timeout"});
    endtask

    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er);
        issue(a, b);
        wait_result(name, eq, er);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'd1;
            4:       v = 32'($urandom_range(0, 20)) - 32'd10;
            5:       v = $urandom >> $urandom_range(0, 31);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quo", dout_quo, 32'd0);
        check("rst_rem", dout_rem, 32'd0);
        #1 rst_n = 1'b1;
        #1 check("ready_before_first_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 check("ready_after_first_edge", {31'd0, in_ready}, 32'd1);

        // Directed cases with hand-computed results.
        run_div("p100_d7",   32'd100,         32'd7,           32'd14,        32'd2);
        run_div("m100_d7",   -32'sd100,       32'd7,           -32'sd14,      -32'sd2);
        run_div("p100_dm7",  32'd100,         -32'sd7,         -32'sd14,      32'd2);
        run_div("div0",      32'd1234,        32'd0,           32'hFFFF_FFFF, 32'd1234);
        run_div("neg_div0",  -32'sd7,         32'd0,           32'hFFFF_FFFF, -32'sd7);
        run_div("min_dm1",   32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000, 32'd0);
        run_div("min_d1",    32'h8000_0000,   32'd1,           32'h8000_0000, 32'd0);
        run_div("p7_dmin",   32'd7,           32'h8000_0000,   32'd0,         32'd7);

        // Backpressure: stall the result for 10 cycles and poke in_valid meanwhile.
        out_ready = 1'b0;
        issue(32'd1000, 32'd3);
        wait_result("bp", 32'd333, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                din0     = 32'd5;
                din1     = 32'd1;
                in_valid = 1'b1;
            end
            if (i == 5) in_valid = 1'b0;
        end
        @(negedge clk);
        check("bp_valid_held", {31'd0, out_valid}, 32'd1);
        check("bp_quo_held", dout_quo, 32'd333);
        check("bp_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ready_after_accept", {31'd0, in_ready}, 32'd1);
        check("bp_valid_after_accept", {31'd0, out_valid}, 32'd0);

        // Randomized back-to-back traffic.
        b2b_mode = 1;
        for (int n = 0; n < 1000; n++) issue(rnd_op(), rnd_op());
        b2b_mode = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (busy) fail_now("drain_timeout");
        @(posedge clk);
        #1;

        // Reset in the middle of a division.
        run_div("pre_reset", 32'd100, 32'd7, 32'd14, 32'd2);
        issue(32'd999, 32'd4);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_quo", dout_quo, 32'd0);
        check("midrst_rem", dout_rem, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("rel_ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 check("rel_ready_after_edge", {31'd0, in_ready}, 32'd1);
        run_div("post_reset", -32'sd100, 32'd7, -32'sd14, -32'sd2);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_fir_sdiv_32s_32s_32_seq.md
# block_fir_sdiv_32s_32s_32_seq

Multi-cycle signed integer divider for the block FIR datapath, producing quotient and remainder of two two's-complement operands. It is the inverse companion of the FIR's combinational signed multiplier and is used for gain normalisation and coefficient rescaling. Operands arrive over a valid/ready handshake, and one radix-2 restoring iteration is performed per clock. Results leave over a second valid/ready handshake. Only one division is in flight at a time.

## Interface
- ID, 1, instance tag; no functional effect
- din0_WIDTH, 32, dividend width in bits
- din1_WIDTH, 32, divisor width in bits; must equal din0_WIDTH
- dout_WIDTH, 32, quotient and remainder width in bits; must equal din0_WIDTH
- ap_clk  in  1  sole clock; all state changes on its rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  din0/din1 valid
- in_ready  out  1  block can accept operands
- din0  in  din0_WIDTH  signed dividend
- din1  in  din1_WIDTH  signed divisor
- out_valid  out  1  quotient/remainder valid
- out_ready  in  1  consumer accepts the result
- dout_quo  out  dout_WIDTH  signed quotient, truncated toward zero
- dout_rem  out  dout_WIDTH  signed remainder; sign follows the dividend

## Operation
- States:
  - IDLE: in_ready=1. On in_valid && in_ready, capture |din0|, |din1|, sign of din0, sign of din1, and a zero-divisor flag; load counter=W (W=din0_WIDTH); go to CALC.
  - CALC: one restoring step per cycle. Shift remainder:dividend left by 1. Trial-subtract the divisor; keep the difference if it is non-negative. Set the quotient bit. Decrement counter. When the counter reaches 1, go to FIX.
  - FIX: apply signs. Quotient is negated if the operand signs differ. Remainder is negated if the dividend is negative. Register the results into dout_quo/dout_rem and go to DONE.
  - DONE: out_valid=1. Hold dout_quo/dout_rem stable until out_ready. On out_valid && out_ready, go to IDLE.
- Arithmetic: magnitudes are held in W+1 bits so that |MIN| is exact. Results are truncated to W bits.
- Divide by zero: dout_quo = all ones (-1); dout_rem = din0. No exception flag is raised. Latency is unchanged.
- Overflow (MIN / -1): dout_quo = MIN (wrap); dout_rem = 0.
- in_ready=0 in CALC, FIX and DONE. in_valid in those states is ignored and its operands are not captured.
- Asserting reset mid-operation aborts the division. The block returns to IDLE and the result is discarded.

## Timing
- Reset values: in_ready=0, out_valid=0, dout_quo=0, dout_rem=0, state=IDLE, counter=0.
- in_ready is registered. It rises on the first rising edge after ap_rst_n deasserts.
- Latency: if operands are accepted at edge 0, out_valid is 1 after edge W+1. For W=32 this is 33 cycles. Latency is data-independent.
- A result accepted at edge n (out_valid && out_ready) gives out_valid=0 and in_ready=1 after edge n. The next operands can be accepted at edge n+1.
- Minimum issue interval is W+3 cycles when out_ready is held at 1.
- Handshake: once out_valid rises it stays high until accepted. dout_quo/dout_rem do not change while out_valid=1 && !out_ready.

## Configuration
- BLOCK_FIR_SDIV_REM_EN:
  - Defined: remainder datapath and sign fixup are built, and dout_rem is valid as specified.
  - Undefined: the remainder fixup logic and the dout_rem register are removed, and dout_rem is tied to 0. The port is retained so the interface is unchanged. Quotient behaviour and latency are identical.

## Structure
- Package block_fir_div_pkg:
  - state enum (IDLE, CALC, FIX, DONE)
  - DIV_W=32
  - counter width localparam, $clog2(DIV_W+1)
  - constant DIV_BY_ZERO_QUO = all ones
- Sub-module block_fir_udiv_step: combinational single restoring iteration.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once in the top module, which owns the state machine, counter, sign capture/fixup and handshake registers.

## Test plan
- Basic: 100 / 7 -> quo 14, rem 2. -100 / 7 -> quo -14, rem -2. 100 / -7 -> quo -14, rem 2. out_valid asserted exactly 33 cycles after accept.
- Divide by zero: 1234 / 0 -> quo 0xFFFFFFFF, rem 1234. Latency is still 33 cycles.
- Overflow and magnitude edges: 0x80000000 / -1 -> quo 0x80000000, rem 0. 0x80000000 / 1 -> quo 0x80000000, rem 0. 7 / 0x80000000 -> quo 0, rem 7.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stay stable and in_ready=0. A new in_valid pulse during the stall is ignored.
- Back-to-back: 1000 random operand pairs with out_ready=1 -> every result matches a reference model. Issue interval is 35 cycles.
- Reset mid-CALC: drop ap_rst_n at cycle 10 of a division -> all outputs are 0 immediately. After release, in_ready=1 one edge later, and the next division is correct.
